tdm_demux_1to4: RTL and testbench



---
 rtl/tdm_demux_1to4_pkg.sv | 20 ++
 rtl/tdm_demux_1to4_sipo_shift.sv | 29 ++
 rtl/tdm_demux_1to4.sv | 110 +++++++++++
 tb/tb_tdm_demux_1to4.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1to4_pkg.sv
// Shared codes for the 4-channel TDM receive demultiplexer.
package tdm_demux_1to4_pkg;

    typedef enum logic [1:0] {
        SLOT_A = 2'b00,
        SLOT_B = 2'b01,
        SLOT_C = 2'b10,
        SLOT_D = 2'b11
    } slot_t;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic slot_t next_slot(input slot_t s);
        return slot_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/tdm_demux_1to4_sipo_shift.sv
// Serial-in parallel-out register; o_word presents the full sample including the bit on i_din.
module sipo_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_shift_en,
    input  logic         i_load_first,
    input  logic         i_din,
    output logic [W-1:0] o_word
);

    // Only W-1 bits are stored: the last bit of a sample is taken straight from i_din.
    logic [W-2:0] r_q;

    assign o_word = {r_q, i_din};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load_first) begin
            r_q    <= '0;
            r_q[0] <= i_din;
        end else if (i_shift_en) begin
            r_q <= o_word[W-2:0];
        end
    end

endmodule

// File: rtl/tdm_demux_1to4.sv
// Receive-side TDM demultiplexer: locks on frame_sync and deserializes slots a..d into parallel outputs.
module tdm_demux_1to4
    import tdm_demux_1to4_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [W-1:0] out_c,
    output logic [W-1:0] out_d,
    output logic [3:0]   ch_valid,
    output logic         frame_done,
    output logic         locked,
    output logic         sync_err
);

    localparam int             CW   = $clog2(W);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t          r_state;
    slot_t           r_slot;
    logic [CW-1:0]   r_bit_cnt;
    logic [W-1:0]    r_out_a;
    logic [W-1:0]    r_out_b;
    logic [W-1:0]    r_out_c;
    logic [W-1:0]    r_out_d;
    logic [3:0]      r_ch_valid;
    logic            r_frame_done;
    logic            r_sync_err;

    logic [W-1:0]    w_word;
    logic            w_run;
    logic            w_accept;
    logic            w_hunt_sync;
    logic            w_resync;

    assign w_run       = (r_state == ST_RUN);
    assign w_accept    = din_valid & w_run;
    assign w_hunt_sync = din_valid & frame_sync & ~w_run;
    // A sync anywhere but the start of slot a restarts the frame on this bit.
    assign w_resync    = w_accept & frame_sync &
                         ~((r_slot == SLOT_A) && (r_bit_cnt == '0));

    sipo_shift #(.W(W)) u_sipo (
        .clk          (clk),
        .rst          (rst),
        .i_shift_en   (w_accept),
        .i_load_first (w_hunt_sync | w_resync),
        .i_din        (din),
        .o_word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_slot       <= SLOT_A;
            r_bit_cnt    <= '0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_c      <= '0;
            r_out_d      <= '0;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            if (w_hunt_sync) begin
                r_state   <= ST_RUN;
                r_slot    <= SLOT_A;
                r_bit_cnt <= CW'(1);
            end else if (w_resync) begin
                r_sync_err <= 1'b1;
                r_slot     <= SLOT_A;
                r_bit_cnt  <= CW'(1);
            end else if (w_accept) begin
                if (r_bit_cnt == LAST) begin
                    case (r_slot)
                        SLOT_A:  r_out_a <= w_word;
                        SLOT_B:  r_out_b <= w_word;
                        SLOT_C:  r_out_c <= w_word;
                        default: r_out_d <= w_word;
                    endcase
                    r_ch_valid   <= 4'b0001 << r_slot;
                    r_frame_done <= (r_slot == SLOT_D);
                    r_bit_cnt    <= '0;
                    r_slot       <= next_slot(r_slot);
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_c      = r_out_c;
    assign out_d      = r_out_d;
    assign ch_valid   = r_ch_valid;
    assign frame_done = r_frame_done;
    assign locked     = w_run;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: frame-position model checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_tdm_demux_1to4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] out_a, out_b, out_c, out_d;
    logic [3:0]   ch_valid;
    logic         frame_done, locked, sync_err;

    tdm_demux_1to4 #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: m_pos is the index of the next bit within a 4*W-bit frame, -1 while hunting.
    int           m_pos = -1;
    logic [31:0]  m_acc = '0;
    logic [W-1:0] e_out [4];
    logic [3:0]   e_chv = '0;
    logic         e_fd = 1'b0;
    logic         e_se = 1'b0;
    int           pcyc = 0;

    always @(posedge clk) begin
        pcyc++;
        e_chv = '0;
        e_fd  = 1'b0;
        e_se  = 1'b0;
        if (rst) begin
            m_pos = -1;
            for (int k = 0; k < 4; k++) e_out[k] = '0;
        end else if (din_valid) begin
            if (frame_sync && m_pos != 0) begin
                e_se  = (m_pos >= 0);
                m_acc = {31'd0, din};
                m_pos = 1;
            end else if (m_pos >= 0) begin
                if (m_pos % W == 0) m_acc = {31'd0, din};
                else                m_acc = {m_acc[30:0], din};
                if (m_pos % W == W - 1) begin
                    e_out[m_pos / W] = m_acc[W-1:0];
                    e_chv[m_pos / W] = 1'b1;
                    e_fd = (m_pos / W == 3);
                end
                m_pos = (m_pos + 1) % (4 * W);
            end
        end
    end

    bit check_en = 1'b0;
    int n_chv [4] = '{0, 0, 0, 0};
    int n_fd = 0;
    int n_se = 0;
    int t_fs = -1;
    int t_cha = -1;
    int t_chd = -1;

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_a", 32'(out_a), 32'(e_out[0]));
            chk("out_b", 32'(out_b), 32'(e_out[1]));
            chk("out_c", 32'(out_c), 32'(e_out[2]));
            chk("out_d", 32'(out_d), 32'(e_out[3]));
            chk("ch_valid", 32'(ch_valid), 32'(e_chv));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("sync_err", 32'(sync_err), 32'(e_se));
            chk("locked", 32'(locked), 32'(m_pos >= 0));
            for (int k = 0; k < 4; k++) if (ch_valid[k]) n_chv[k]++;
            if (frame_done) n_fd++;
            if (sync_err) n_se++;
            if (ch_valid[0] && t_cha < 0) t_cha = pcyc;
            if (ch_valid[3] && t_chd < 0) t_chd = pcyc;
        end
    end

    task automatic clr_stats();
        for (int k = 0; k < 4; k++) n_chv[k] = 0;
        n_fd = 0; n_se = 0; t_fs = -1; t_cha = -1; t_chd = -1;
    endtask

    // Stall cycles hold frame_sync high to show it is ignored without din_valid.
    task automatic send_bit(input logic d, input logic fs, input bit stall);
        @(negedge clk);
        din = d; frame_sync = fs; din_valid = 1'b1;
        if (fs) t_fs = pcyc + 1;
        if (stall) begin
            @(negedge clk);
            din = ~d; frame_sync = 1'b1; din_valid = 1'b0;
        end
    endtask

    task automatic send_sample(input logic [W-1:0] v, input logic fs, input bit stall);
        for (int i = W - 1; i >= 0; i--) send_bit(v[i], fs && (i == W - 1), stall);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0; frame_sync = 1'b0;
        end
    endtask

    task automatic reset_dut(input int n);
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] a, b, c, d, input logic fs, input bit stall);
        send_sample(a, fs, stall);
        send_sample(b, 1'b0, stall);
        send_sample(c, 1'b0, stall);
        send_sample(d, 1'b0, stall);
    endtask

    initial begin
        reset_dut(2);
        check_en = 1'b1;
        chk("rst_out_a", 32'(out_a), 32'h0);
        chk("rst_out_d", 32'(out_d), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_ch_valid", 32'(ch_valid), 32'h0);

        // Lock and decode one frame with continuous valid.
        clr_stats();
        send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1, 1'b0);
        idle(3);
        chk("t1_out_a", 32'(out_a), 32'hA5);
        chk("t1_out_b", 32'(out_b), 32'h3C);
        chk("t1_out_c", 32'(out_c), 32'h0F);
        chk("t1_out_d", 32'(out_d), 32'hF0);
        chk("t1_locked", 32'(locked), 32'h1);
        chk("t1_lat_a", 32'(t_cha - t_fs), 32'd7);
        chk("t1_lat_d", 32'(t_chd - t_fs), 32'd31);
        chk("t1_n_fd", 32'(n_fd), 32'd1);
        chk("t1_n_chv_c", 32'(n_chv[2]), 32'd1);

        // Same frame with a stall after every bit.
        clr_stats();
        send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1, 1'b1);
        idle(3);
        chk("t2_out_b", 32'(out_b), 32'h3C);
        chk("t2_lat_a", 32'(t_cha - t_fs), 32'd14);
        chk("t2_lat_d", 32'(t_chd - t_fs), 32'd62);
        chk("t2_n_se", 32'(n_se), 32'd0);

        // Bits before the first sync are discarded.
        reset_dut(1);
        clr_stats();
        for (int i = 0; i < 20; i++) send_bit(logic'(i % 3 == 0), 1'b0, 1'b0);
        idle(2);
        chk("t3_hunt_strobes", 32'(n_chv[0] + n_chv[1] + n_chv[2] + n_chv[3]), 32'd0);
        chk("t3_hunt_locked", 32'(locked), 32'h0);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0);
        idle(3);
        chk("t3_out_a", 32'(out_a), 32'h11);
        chk("t3_out_d", 32'(out_d), 32'h44);

        // Sync arriving at bit 3 of slot b.
        clr_stats();
        send_sample(8'h5A, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_sample(8'h96, 1'b1, 1'b0);
        idle(3);
        chk("t4_n_se", 32'(n_se), 32'd1);
        chk("t4_n_chv_b", 32'(n_chv[1]), 32'd0);
        chk("t4_out_b", 32'(out_b), 32'h22);
        chk("t4_out_a", 32'(out_a), 32'h96);

        // Reset in the middle of slot c, with a valid bit present on the reset edge.
        reset_dut(1);
        clr_stats();
        send_sample(8'h77, 1'b1, 1'b0);
        send_sample(8'h88, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; din = 1'b1; din_valid = 1'b1; frame_sync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_out_a", 32'(out_a), 32'h0);
        chk("t5_out_b", 32'(out_b), 32'h0);
        chk("t5_locked", 32'(locked), 32'h0);
        for (int i = 0; i < 12; i++) send_bit(logic'(i % 2), 1'b0, 1'b0);
        idle(2);
        chk("t5_n_chv_a", 32'(n_chv[0]), 32'd1);
        chk("t5_n_chv_c", 32'(n_chv[2]), 32'd0);
        chk("t5_locked_after", 32'(locked), 32'h0);

        // Second frame decoded from free-running count, no sync on it.
        clr_stats();
        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b0);
        send_frame(8'h9A, 8'hBC, 8'hDE, 8'hF1, 1'b0, 1'b0);
        idle(3);
        chk("t6_out_a", 32'(out_a), 32'h9A);
        chk("t6_out_b", 32'(out_b), 32'hBC);
        chk("t6_out_c", 32'(out_c), 32'hDE);
        chk("t6_out_d", 32'(out_d), 32'hF1);
        chk("t6_n_se", 32'(n_se), 32'd0);
        chk("t6_n_fd", 32'(n_fd), 32'd2);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
